// File: rtl/p2r8_booth_enc_if.sv
// Operand and result channels of the radix-8 Booth encoder.
// Both sides use valid/ready: a beat transfers on a rising CLK edge where valid and ready are both high; a producer holding valid keeps its payload unchanged until that edge.
interface p2r8_booth_enc_if #(
  parameter int WIDTH = 8
);
  localparam int GROUPS = (WIDTH + 2) / 3;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic              out_valid;
  logic              out_ready;
  logic [GROUPS-1:0] s;
  logic [GROUPS-1:0] d;
  logic [GROUPS-1:0] t;
  logic [GROUPS-1:0] q;
  logic [GROUPS-1:0] n;
  logic [WIDTH-1:0]  my;
  logic [WIDTH+1:0]  tmy;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, s, d, t, q, n, my, tmy
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, s, d, t, q, n, my, tmy
  );
endinterface

// File: rtl/p2r8_booth_enc.sv
// Radix-8 Booth recoder: two-stage elastic pipeline turning multiplier x into per-group
// digit flags and precomputing the 3*y partial-product multiple for the downstream array.
module p2r8_booth_enc #(
  parameter int WIDTH = 8,
  localparam int GROUPS = (WIDTH + 2) / 3
) (
  input logic              CLK,
  input logic              RST,
  p2r8_booth_enc_if.slave  bus
);
  // x padded with the implicit x[-1]=0 below and sign copies above, so every group sees 4 real bits
  localparam int XEW = 3 * GROUPS + 1;

  logic             v1;
  logic             v2;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             in_fire;
  logic             adv;
  logic [XEW-1:0]   xe;

  logic [GROUPS-1:0] s_c;
  logic [GROUPS-1:0] d_c;
  logic [GROUPS-1:0] t_c;
  logic [GROUPS-1:0] q_c;
  logic [GROUPS-1:0] n_c;
  logic [WIDTH+1:0]  tmy_c;

  assign bus.in_ready  = !RST && (!v1 || !v2 || bus.out_ready);
  assign bus.out_valid = v2;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign adv           = v1 && (!v2 || bus.out_ready);

  assign xe = {{(XEW - 1 - WIDTH){x1[WIDTH-1]}}, x1, 1'b0};

  // Window is {b3,b2,b1,b0}; digit = -4*b3 + 2*b2 + b1 + b0. 0000 and 1111 both encode zero.
  always_comb begin
    s_c = '0;
    d_c = '0;
    t_c = '0;
    q_c = '0;
    n_c = '0;
    for (int i = 0; i < GROUPS; i++) begin
      case (xe[3*i +: 4])
        4'b0001, 4'b0010: s_c[i] = 1'b1;
        4'b0011, 4'b0100: d_c[i] = 1'b1;
        4'b0101, 4'b0110: t_c[i] = 1'b1;
        4'b0111:          q_c[i] = 1'b1;
        4'b1000: begin
          q_c[i] = 1'b1;
          n_c[i] = 1'b1;
        end
        4'b1001, 4'b1010: begin
          t_c[i] = 1'b1;
          n_c[i] = 1'b1;
        end
        4'b1011, 4'b1100: begin
          d_c[i] = 1'b1;
          n_c[i] = 1'b1;
        end
        4'b1101, 4'b1110: begin
          s_c[i] = 1'b1;
          n_c[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Two extra bits make y + 2y exact for every signed y.
  assign tmy_c = {{2{y1[WIDTH-1]}}, y1} + {y1[WIDTH-1], y1, 1'b0};

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      x1      <= '0;
      y1      <= '0;
      bus.s   <= '0;
      bus.d   <= '0;
      bus.t   <= '0;
      bus.q   <= '0;
      bus.n   <= '0;
      bus.my  <= '0;
      bus.tmy <= '0;
    end else begin
      if (in_fire) begin
        v1 <= 1'b1;
        x1 <= bus.x;
        y1 <= bus.y;
      end else if (adv) begin
        v1 <= 1'b0;
      end

      // S2 only reloads when S1 advances, so a stalled result stays frozen
      if (adv) begin
        v2      <= 1'b1;
        bus.s   <= s_c;
        bus.d   <= d_c;
        bus.t   <= t_c;
        bus.q   <= q_c;
        bus.n   <= n_c;
        bus.my  <= y1;
        bus.tmy <= tmy_c;
      end else if (bus.out_ready) begin
        v2 <= 1'b0;
      end
    end
  end
endmodule
